dbi_bus_scheduler: RTL
======================

// Module: dbi_bus_scheduler
// PURPOSE
//  Round-robin scheduler sharing one DBI-encoded output bus among NREQ requesters.
//  - Picks one requester word per accepted beat and applies the data-bus-inversion decision inline.
//  - Launches {bus_dbi, bus_data} with a valid/ready handshake.
//  - Sits between the systolic-array output collectors and the wide inter-block bus.
//  - Holds a granted requester for short bursts to cut inter-source toggling.
// PARAMETERS
//  BW        128  bus data width (bits); even, >=8
//  NREQ      4    number of requesters; 2..8
//  MAX_BURST 4    max consecutive beats one requester may hold the grant; >=1
// PORTS
//  clk        input   1          rising-edge clock
//  reset      input   1          asynchronous, active-low reset (0 = reset)
//  dbi_en     input   1          1: DBI encoding active; 0: data passed through, bus_dbi=0
//  req_valid  input   NREQ       per-requester word valid
//  req_data   input   NREQ*BW    packed words; requester i at [i*BW +: BW]
//  req_ready  output  NREQ       one-hot (or zero) accept strobe
//  bus_valid  output  1          output beat valid
//  bus_ready  input   1          downstream accepts beat
//  bus_data   output  BW         encoded word (inverted when bus_dbi=1)
//  bus_dbi    output  1          inversion flag for bus_data
//  bus_src    output  log2(NREQ) index of requester that produced current beat (min width 1)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - bus_valid=0, bus_data=0, bus_dbi=0, bus_src=0, req_ready=0.
//   - rr_ptr=0, burst_cnt=0, state=IDLE.
//  Accept condition: slot_free = !bus_valid || bus_ready. A beat is accepted only when slot_free=1.
//   - req_ready[g]=1 combinationally for the selected g, same cycle. All other bits are 0.
//   - req_ready is never asserted for a requester with req_valid=0.
//  Latency: accepted word appears on bus_* the next cycle (1-cycle register stage).
//   - Full throughput of 1 beat/cycle while bus_ready=1.
//  Backpressure: bus_valid && !bus_ready holds bus_data/bus_dbi/bus_src stable; req_ready=0.
//  DBI decision, against ref = current bus_data register (last launched word, held on wires when idle):
//   - ones = popcount(ref ^ w), counted exactly over BW bits.
//   - dbi_en=1 and ones > BW/2: bus_data<=~w, bus_dbi<=1.
//   - Otherwise: bus_data<=w, bus_dbi<=0. ones==BW/2 is NOT inverted.
//   - dbi_en=0: plain pass-through, bus_dbi=0. ref still tracks the launched word.
//  Arbitration FSM:
//   - IDLE: on slot_free, choose first valid i scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//     Set owner=i, burst_cnt=1, go to BURST (if MAX_BURST>1). rr_ptr<=(i+1) mod NREQ.
//   - BURST: on slot_free, owner still valid and burst_cnt<MAX_BURST -> accept owner, burst_cnt++.
//     Owner valid but burst_cnt==MAX_BURST, or owner invalid: re-arbitrate as in IDLE this same cycle.
//     No bubble. Owner is excluded only if another requester is valid.
//     No requester valid -> IDLE.
//   - No slot_free: state, owner, burst_cnt frozen.
//  Wrap: rr_ptr wraps NREQ-1 -> 0. A single valid requester may stream indefinitely in MAX_BURST chunks.
//  Simultaneous: transfer out (valid&&ready) and new accept in the same cycle is legal. ref is the outgoing word.
//  dbi_en change takes effect on the next accepted word; a launched beat is never re-encoded.
//  Reset mid-burst: pending beat is dropped, bus returns to reset values; upstream must re-present.
// CONFIGURATION
//  DBI_STATS_EN defined: adds outputs stat_beats[31:0] and stat_inv[31:0].
//   - stat_beats counts transferred beats (bus_valid && bus_ready).
//   - stat_inv counts those with bus_dbi=1.
//   - Both saturate at 32'hFFFF_FFFF, reset to 0, and are cleared by input stat_clr (1 cycle, has priority).
//  Undefined: stat_* and stat_clr ports and logic absent. All other behaviour identical.
// TESTING
//  1. reset=0 with random inputs -> all outputs at reset values. Release, req_valid=0 -> bus_valid stays 0.
//  2. dbi_en=1, ref=0, req0 data=128'hFFFF..FFFF (ones=128) -> bus_data=0, bus_dbi=1, 1 cycle later.
//     Next req0 word=0 -> ones=0, bus_data=0, bus_dbi=0.
//  3. ref=0, word with exactly 64 ones -> bus_dbi=0. Word with 65 ones -> bus_dbi=1, bus_data=~word.
//  4. All 4 requesters valid continuously, bus_ready=1, MAX_BURST=4 -> bus_src = 0,0,0,0,1,1,1,1,2.. ,3.., then 0.
//     Exactly one req_ready high per cycle.
//  5. bus_ready=0 for 5 cycles while beat pending -> bus_* stable, req_ready=0.
//     On release, next beat follows with no bubble.
//  6. dbi_en=0, word=all-ones after ref=0 -> bus_data=all-ones, bus_dbi=0.
//     With DBI_STATS_EN, test 2 gives stat_beats=2, stat_inv=1.

Source files
------------

// File: rtl/dbi_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dbi_bus_scheduler
// Description : Round-robin scheduler that shares one DBI-encoded output bus
//               among NREQ requesters. A granted requester keeps the bus for
//               bursts of up to MAX_BURST beats. Each accepted word is encoded
//               inline against the word currently on the bus and launched
//               through a single register stage with a valid/ready handshake.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-low reset (0 = reset)
//               dbi_en     - 1: data-bus inversion active, 0: pass-through
//               req_valid  - per-requester word valid
//               req_data   - packed words, requester i at [i*BW +: BW]
//               req_ready  - one-hot (or zero) accept strobe, same cycle
//               bus_valid  - output beat valid
//               bus_ready  - downstream accepts the beat
//               bus_data   - encoded word (inverted when bus_dbi=1)
//               bus_dbi    - inversion flag for bus_data
//               bus_src    - index of the requester that produced the beat
//               stat_clr   - (DBI_STATS_EN) clear both statistics counters
//               stat_beats - (DBI_STATS_EN) transferred beat count, saturating
//               stat_inv   - (DBI_STATS_EN) transferred inverted beats, saturating
// Options     : define DBI_STATS_EN to add the statistics counters and ports.
// Revision    : 1.0 - initial release
// ============================================================================
module dbi_bus_scheduler #(
  parameter  int BW        = 128,
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 4,
  localparam int SW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dbi_en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*BW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [BW-1:0]      bus_data,
  output logic               bus_dbi,
  output logic [SW-1:0]      bus_src
`ifdef DBI_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_beats,
  output logic [31:0]        stat_inv
`endif
);

  localparam int SWP = SW + 1;
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int OW  = $clog2(BW + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [SW-1:0] r_owner, w_owner_nxt;
  logic [SW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;

  logic          w_slot_free;
  logic          w_accept;
  logic [SW-1:0] w_grant;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic [BW-1:0] w_word;
  logic [BW-1:0] w_diff;
  logic [OW-1:0] w_ones;
  logic          w_invert;

  // A new word may enter the output register when it is empty or draining.
  assign w_slot_free = !bus_valid || bus_ready;

  // Round-robin scan starting at rr_ptr. rr_ptr is always owner+1, so the
  // current owner is reached last and only wins when nobody else is valid.
  always_comb begin
    logic [SW:0] cand;
    cand       = '0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, r_rr_ptr} + SWP'(k);
      if (cand >= SWP'(NREQ)) begin
        cand = cand - SWP'(NREQ);
      end
      if (!w_rr_found && req_valid[cand[SW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand[SW-1:0];
      end
    end
  end

  // FSM: state register (state plus owner, burst counter and pointer).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // FSM: next-state and grant selection. Re-arbitration happens in the same
  // cycle the burst ends, so there is never a bubble between owners.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_accept        = 1'b0;
    w_grant         = r_owner;
    if (reset && w_slot_free) begin
      if ((r_state == S_BURST) && req_valid[r_owner] &&
          (r_burst_cnt < CW'(MAX_BURST))) begin
        w_accept        = 1'b1;
        w_grant         = r_owner;
        w_burst_cnt_nxt = r_burst_cnt + CW'(1);
      end else if (w_rr_found) begin
        w_accept        = 1'b1;
        w_grant         = w_rr_idx;
        w_owner_nxt     = w_rr_idx;
        w_burst_cnt_nxt = CW'(1);
        w_rr_ptr_nxt    = (w_rr_idx == SW'(NREQ - 1)) ? '0 : (w_rr_idx + SW'(1));
        w_state_nxt     = (MAX_BURST > 1) ? S_BURST : S_IDLE;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // FSM: outputs. Accept strobe is one-hot on the granted requester.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready = NREQ'(1) << w_grant;
    end
  end

  // Word mux and DBI decision against the word currently held on the bus.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant == SW'(k)) begin
        w_word = req_data[k*BW +: BW];
      end
    end
    w_diff = bus_data ^ w_word;
    w_ones = '0;
    for (int k = 0; k < BW; k++) begin
      w_ones = w_ones + OW'(w_diff[k]);
    end
    // Exactly half toggling is left uninverted.
    w_invert = dbi_en && (w_ones > OW'(BW / 2));
  end

  // Output register stage. bus_data keeps the last launched word when idle
  // because it is the reference for the next DBI decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_dbi   <= 1'b0;
      bus_src   <= '0;
    end else if (w_accept) begin
      bus_valid <= 1'b1;
      bus_data  <= w_invert ? ~w_word : w_word;
      bus_dbi   <= w_invert;
      bus_src   <= w_grant;
    end else if (bus_ready) begin
      bus_valid <= 1'b0;
    end
  end

`ifdef DBI_STATS_EN
  // Saturating transfer statistics; clear wins over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_beats <= '0;
      stat_inv   <= '0;
    end else if (stat_clr) begin
      stat_beats <= '0;
      stat_inv   <= '0;
    end else if (bus_valid && bus_ready) begin
      if (stat_beats != 32'hFFFF_FFFF) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (bus_dbi && (stat_inv != 32'hFFFF_FFFF)) begin
        stat_inv <= stat_inv + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
